dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory bus responder for the single-cycle RISC-V core: the target end of the core's data interface (address, write data, write strobe, access type, ready). Holds a word-organised synchronous RAM and performs byte-lane steering for stores, lane extraction with sign or zero extension for loads, misalignment detection, and a configurable wait-state handshake that drives the core's ready input.

## Interface
- ADDR_WIDTH, 10: log2 of RAM depth in 32-bit words; word index = addr[ADDR_WIDTH+1:2].
- WAIT_CYCLES, 1: extra wait states between ACCESS and RESP; 0..15.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; resets control state only, not RAM contents.
- req  in  1  core requests a data access; held until ready.
- mem_w  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- dm_type  in  3  access type (package encoding).
- rdata  out  32  load result, extended to 32 bits; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- misalign  out  1  qualifies ready: access was misaligned and suppressed.

## Operation
- dm_type encoding: DM_WORD=3'b000, DM_HALFWORD=3'b001, DM_HALFWORD_UNSIGNED=3'b010, DM_BYTE=3'b011, DM_BYTE_UNSIGNED=3'b100; other values are treated as DM_WORD.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if req=1, latch mem_w, addr, wdata, and dm_type; go to ACCESS.
  - ACCESS: go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: down-counter loaded with WAIT_CYCLES on entry; go to RESP when it reaches 1.
  - RESP: go to IDLE.
- Store, committed at the end of the ACCESS cycle:
  - Byte: wdata[7:0] is replicated to all lanes; byte enable is 4'b0001<<addr[1:0].
  - Halfword: wdata[15:0] is replicated; enable is 4'b0011<<addr[1:0].
  - Word: enable is 4'b1111.
  - Unselected bytes are unchanged.
- Load: RAM word is registered at the end of ACCESS.
  - Lane selected by latched addr[1:0].
  - Byte/halfword sign-extended for DM_BYTE/DM_HALFWORD; zero-extended for the unsigned types.
- Misaligned access (halfword with addr[0]=1; word with addr[1:0]!=0):
  - No RAM write.
  - RESP has misalign=1 and rdata=0.
- Address bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo RAM size.
- Inputs are ignored outside IDLE. Deasserting req mid-transaction does not abort it.

## Timing
- Reset values: ready=0, misalign=0, rdata=0, state=IDLE, counter=0.
- req sampled high in IDLE in cycle 0 → ACCESS in cycle 1 → WAIT in cycles 2..1+WAIT_CYCLES → RESP in cycle 2+WAIT_CYCLES.
  - ready, rdata and misalign are registered outputs, high/valid exactly during RESP.
- Next request is accepted no earlier than the cycle after RESP.
  - A req held continuously through RESP starts a new transaction on the following IDLE cycle.
  - Minimum back-to-back period is 3+WAIT_CYCLES cycles.
- Store followed by a load to the same word returns the new data.
- Reset asserted during ACCESS: the store still commits at that edge, the FSM returns to IDLE, and no ready is issued.
- Reset asserted during WAIT or RESP: the FSM returns to IDLE, ready=0, and stored data persists.
- Reset and req in the same cycle: reset wins and the request is not latched.

## Structure
- Package dm_pkg holds the DM_* constants, the state enumeration, and the byte-enable widths.
- Sub-module dmem_lane_align is combinational. It takes dm_type, addr[1:0], wdata and the RAM word, and produces:
  - store lane data and byte enables;
  - the extended load value;
  - the misalign flag.
- The top level holds the FSM, the wait counter, the latched request, and a byte-enabled RAM array inferred as block RAM.

## Test plan
- WAIT_CYCLES=1: store DM_WORD 0x12345678 at 0x10, then load DM_WORD from 0x10 → rdata=0x12345678; ready is high exactly in cycle 3 after each req.
- After the above, load DM_BYTE_UNSIGNED at 0x13 → 0x00000012; load DM_HALFWORD at 0x12 → 0x00001234.
- Store DM_BYTE wdata=0xAB80 at 0x11 → word becomes 0x12348078; load DM_BYTE at 0x11 → 0xFFFFFF80; load DM_BYTE_UNSIGNED at 0x11 → 0x00000080.
- Store DM_HALFWORD at 0x11 → ready=1, misalign=1, word unchanged at 0x12348078; load DM_WORD at 0x12 → misalign=1, rdata=0.
- Reset asserted during WAIT of a load → no ready pulse, FSM in IDLE the next cycle; a following load from 0x10 returns 0x12348078.
- WAIT_CYCLES=0 with req held high continuously → a ready pulse every 3 cycles; address 0x1010 with ADDR_WIDTH=10 aliases to 0x10.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared access-type encodings, FSM states and lane widths for dmem_responder
package dm_pkg;

  typedef logic [2:0] dm_type_t;

  localparam dm_type_t DM_WORD              = 3'b000;
  localparam dm_type_t DM_HALFWORD          = 3'b001;
  localparam dm_type_t DM_HALFWORD_UNSIGNED = 3'b010;
  localparam dm_type_t DM_BYTE              = 3'b011;
  localparam dm_type_t DM_BYTE_UNSIGNED     = 3'b100;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Undefined encodings behave as full-word accesses.
  function automatic dm_type_t dm_norm(input dm_type_t t);
    return (t > DM_BYTE_UNSIGNED) ? DM_WORD : t;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension and misalignment check
module dmem_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]        dm_type_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] st_data_o,
  output logic [BE_W-1:0]   st_be_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              misalign_o
);

  dm_type_t          t;
  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic              mis;

  always_comb begin
    t         = dm_norm(dm_type_i);
    sh        = {addr_lo_i, 3'b000};
    shifted   = rword_i >> sh;
    st_data_o = wdata_i;
    st_be_o   = 4'b1111;
    ld_data_o = rword_i;
    mis       = 1'b0;
    case (t)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
        mis       = addr_lo_i[0];
        st_data_o = {2{wdata_i[15:0]}};
        st_be_o   = 4'b0011 << addr_lo_i;
        ld_data_o = (t == DM_HALFWORD) ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'h0000, shifted[15:0]};
      end
      DM_BYTE, DM_BYTE_UNSIGNED: begin
        st_data_o = {4{wdata_i[7:0]}};
        st_be_o   = 4'b0001 << addr_lo_i;
        ld_data_o = (t == DM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
      end
      default: mis = |addr_lo_i;
    endcase
    // A misaligned access must neither write nor return data.
    if (mis) begin
      st_be_o   = '0;
      ld_data_o = '0;
    end
    misalign_o = mis;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: request FSM, wait states and byte-enabled RAM
module dmem_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  w_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            type_q;
  logic [DATA_W-1:0]     rword_q;
  logic                  ready_q;
  logic                  mis_q;

  logic [DATA_W-1:0]     st_data;
  logic [BE_W-1:0]       st_be;
  logic [DATA_W-1:0]     ld_data;
  logic                  mis_flag;
  logic [ADDR_WIDTH-1:0] word_idx;

  logic [DATA_W-1:0]     mem [DEPTH];

  // Upper address bits are intentionally dropped so accesses wrap modulo RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr[31:ADDR_WIDTH+2]};

  assign word_idx = addr_q[ADDR_WIDTH+1:2];

  dmem_lane_align u_align (
    .dm_type_i  (type_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rword_i    (rword_q),
    .st_data_o  (st_data),
    .st_be_o    (st_be),
    .ld_data_o  (ld_data),
    .misalign_o (mis_flag)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      w_q     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= DM_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_RESP);
      mis_q   <= (state_d == ST_RESP) && mis_flag;
      if (state_q == ST_IDLE && req) begin
        w_q     <= mem_w;
        addr_q  <= addr[ADDR_WIDTH+1:0];
        wdata_q <= wdata;
        type_q  <= dm_type;
      end
    end
  end

  // RAM is outside the reset domain so a store in ACCESS commits even under reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS) begin
      rword_q <= mem[word_idx];
      if (w_q) begin
        for (int i = 0; i < BE_W; i++) begin
          if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign ready    = ready_q;
  assign misalign = mis_q;
  assign rdata    = ready_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req_a, req_b, mem_w;
  logic [31:0] addr, wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, mis_a, mis_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .dm_type(dm_type), .rdata(rdata_a), .ready(ready_a),
    .misalign(mis_a)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .dm_type(dm_type), .rdata(rdata_b), .ready(ready_b),
    .misalign(mis_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] t, output logic [31:0] rd, output logic mis, output int lat);
    int i;
    @(negedge clk);
    mem_w = we; addr = a; wdata = wd; dm_type = t;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    lat = 0; rd = 32'hDEADBEEF; mis = 1'b0; i = 0;
    while (lat == 0 && i < 20) begin
      @(negedge clk);
      i++;
      if (sel ? ready_b : ready_a) begin
        lat = i;
        rd  = sel ? rdata_b : rdata_a;
        mis = sel ? mis_b : mis_a;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic txn(input string tag, input bit sel, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] t, input logic [31:0] exp_rd,
                     input bit chk_rd, input logic exp_mis);
    logic [31:0] rd;
    logic        mis;
    int          lat;
    acc(sel, we, a, wd, t, rd, mis, lat);
    check({tag, "_lat"}, 32'(lat), sel ? 32'd2 : 32'd3);
    check({tag, "_mis"}, {31'd0, mis}, {31'd0, exp_mis});
    if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, sel ? ready_b : ready_a}, 32'd0);
  endtask

  initial begin
    logic [15:0] pv;
    logic        seen, rd_ok;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; mem_w = 1'b0;
    addr = '0; wdata = '0; dm_type = DM_WORD;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_mis", {31'd0, mis_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_state", {30'd0, dut_a.state_q}, {30'd0, ST_IDLE});

    // reset and req together: request must be dropped
    req_a = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    check("rst_req_state", {30'd0, dut_a.state_q}, {30'd0, ST_IDLE});
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= ready_a; end
    check("rst_req_noready", {31'd0, seen}, 32'd0);

    txn("st_w10", 0, 1, 32'h10, 32'h12345678, DM_WORD, 0, 0, 1'b0);
    txn("ld_w10", 0, 0, 32'h10, 0, DM_WORD, 32'h12345678, 1, 1'b0);
    txn("ld_bu13", 0, 0, 32'h13, 0, DM_BYTE_UNSIGNED, 32'h00000012, 1, 1'b0);
    txn("ld_h12", 0, 0, 32'h12, 0, DM_HALFWORD, 32'h00001234, 1, 1'b0);
    txn("st_b11", 0, 1, 32'h11, 32'h0000AB80, DM_BYTE, 0, 0, 1'b0);
    txn("ld_w10b", 0, 0, 32'h10, 0, DM_WORD, 32'h12348078, 1, 1'b0);
    txn("ld_b11", 0, 0, 32'h11, 0, DM_BYTE, 32'hFFFFFF80, 1, 1'b0);
    txn("ld_bu11", 0, 0, 32'h11, 0, DM_BYTE_UNSIGNED, 32'h00000080, 1, 1'b0);
    txn("ld_h10", 0, 0, 32'h10, 0, DM_HALFWORD, 32'hFFFF8078, 1, 1'b0);
    txn("ld_hu10", 0, 0, 32'h10, 0, DM_HALFWORD_UNSIGNED, 32'h00008078, 1, 1'b0);
    txn("st_h11_mis", 0, 1, 32'h11, 32'h0000FFFF, DM_HALFWORD, 0, 0, 1'b1);
    txn("ld_w10c", 0, 0, 32'h10, 0, DM_WORD, 32'h12348078, 1, 1'b0);
    txn("ld_w12_mis", 0, 0, 32'h12, 0, DM_WORD, 32'h00000000, 1, 1'b1);
    txn("ld_t7", 0, 0, 32'h10, 0, 3'b111, 32'h12348078, 1, 1'b0);

    // reset during WAIT of a load
    @(negedge clk);
    mem_w = 1'b0; addr = 32'h10; dm_type = DM_WORD; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    check("wait_state", {30'd0, dut_a.state_q}, {30'd0, ST_WAIT});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_state", {30'd0, dut_a.state_q}, {30'd0, ST_IDLE});
    seen = ready_a;
    repeat (3) begin @(negedge clk); seen |= ready_a; end
    check("rstw_noready", {31'd0, seen}, 32'd0);
    txn("ld_after_rst", 0, 0, 32'h10, 0, DM_WORD, 32'h12348078, 1, 1'b0);

    // zero wait states, aliasing and continuous req
    txn("b_st_1010", 1, 1, 32'h1010, 32'hCAFEF00D, DM_WORD, 0, 0, 1'b0);
    txn("b_ld_10", 1, 0, 32'h10, 0, DM_WORD, 32'hCAFEF00D, 1, 1'b0);
    @(negedge clk);
    mem_w = 1'b0; addr = 32'h10; dm_type = DM_WORD; req_b = 1'b1;
    pv = '0; rd_ok = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      pv[i] = ready_b;
      if (ready_b && rdata_b !== 32'hCAFEF00D) rd_ok = 1'b0;
    end
    req_b = 1'b0;
    check("b_pulse_train", {16'd0, pv}, 32'h00000924);
    check("b_train_rdata", {31'd0, rd_ok}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
